// File: rtl/doy_date_seq.sv
// Sequential day-of-year to calendar-date converter.
// Takes a day number (1..365/366) and a leap flag through a start/busy/done
// handshake. The month is found by subtracting one month length per cycle,
// and the day digits by repeated subtract-10. Outputs are BCD digits plus
// seven-segment codes for the display path.
module doy_date_seq #(
  parameter int unsigned DOY_W          = 9,
  parameter int unsigned LEAP_EN        = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DOY_W-1:0] doy,
  input  logic             leap,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [3:0]       month_tens,
  output logic [3:0]       month_ones,
  output logic [3:0]       day_tens,
  output logic [3:0]       day_ones,
  output logic [6:0]       seg_mt,
  output logic [6:0]       seg_mo,
  output logic [6:0]       seg_dt,
  output logic [6:0]       seg_do
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_BCD,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state, state_nxt;
  logic [DOY_W-1:0] rem;
  logic [3:0]       m;
  logic             leap_q;
  logic             bad_q;
  logic [4:0]       day;
  logic [1:0]       tens;
  logic             leap_eff;
  logic [DOY_W-1:0] year_len;
  logic             bad_in;
  logic             accept;
  logic [DOY_W-1:0] len_cur;

  function automatic logic [DOY_W-1:0] month_len(input logic [3:0] mm, input logic lp);
    logic [4:0] d;
    case (mm)
      4'd2:                      d = lp ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   d = 5'd30;
      default:                   d = 5'd31;
    endcase
    return DOY_W'(d);
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'd0:    p = 7'b0111111;
      4'd1:    p = 7'b0000110;
      4'd2:    p = 7'b1011011;
      4'd3:    p = 7'b1001111;
      4'd4:    p = 7'b1100110;
      4'd5:    p = 7'b1101101;
      4'd6:    p = 7'b1111101;
      4'd7:    p = 7'b0000111;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1101111;
      default: p = 7'b0000000;
    endcase
    return (SEG_ACTIVE_LOW != 0) ? ~p : p;
  endfunction

  assign leap_eff = leap & (LEAP_EN != 0);
  assign year_len = leap_eff ? DOY_W'(366) : DOY_W'(365);
  assign bad_in   = (doy == '0) || (doy > year_len);
  assign accept   = (state == S_IDLE) && start;
  assign len_cur  = month_len(m, leap_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. The range verdict is captured at accept and acted on
  // in the first CALC cycle, which gives out-of-range requests one cycle of
  // latency without a separate check state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_CALC;
      S_CALC: begin
        if (bad_q)               state_nxt = S_ERR;
        else if (rem <= len_cur) state_nxt = S_BCD;
      end
      S_BCD:  if (day < 5'd10) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      S_ERR:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE) || (state == S_ERR);
  end

  // Datapath: month walk, day split, and result registers updated only on the done edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem        <= '0;
      m          <= '0;
      leap_q     <= 1'b0;
      bad_q      <= 1'b0;
      day        <= '0;
      tens       <= '0;
      error      <= 1'b0;
      month_tens <= '0;
      month_ones <= '0;
      day_tens   <= '0;
      day_ones   <= '0;
    end else begin
      if (accept) begin
        rem    <= doy;
        m      <= 4'd1;
        leap_q <= leap_eff;
        bad_q  <= bad_in;
      end
      if (state == S_CALC) begin
        if (bad_q) begin
          error <= 1'b1;
        end else if (rem <= len_cur) begin
          day  <= rem[4:0];
          tens <= '0;
        end else begin
          rem <= rem - len_cur;
          m   <= m + 4'd1;
        end
      end
      if (state == S_BCD) begin
        if (day >= 5'd10) begin
          day  <= day - 5'd10;
          tens <= tens + 2'd1;
        end else begin
          error      <= 1'b0;
          month_tens <= (m >= 4'd10) ? 4'd1 : 4'd0;
          month_ones <= (m >= 4'd10) ? (m - 4'd10) : m;
          day_tens   <= {2'b00, tens};
          day_ones   <= day[3:0];
        end
      end
    end
  end

  // Segment drivers from the registered BCD digits
  always_comb begin
    seg_mt = seg7(month_tens);
    seg_mo = seg7(month_ones);
    seg_dt = seg7(day_tens);
    seg_do = seg7(day_ones);
  end

endmodule

// File: tb/tb_doy_date_seq.sv
// Self-checking bench for doy_date_seq: directed corner cases, randomized
// requests and a full-year sweep, compared against a cumulative-table calendar.
module tb_doy_date_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, leap;
  logic [8:0] doy;
  logic       busy, done, error;
  logic [3:0] month_tens, month_ones, day_tens, day_ones;
  logic [6:0] seg_mt, seg_mo, seg_dt, seg_do;

  logic       start2, leap2;
  logic [9:0] doy2;
  logic       busy2, done2, error2;
  logic [3:0] mt2, mo2, dt2, do2;
  logic [6:0] smt2, smo2, sdt2, sdo2;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned done_cnt = 0;
  int unsigned e_mt = 0, e_mo = 0, e_dt = 0, e_do = 0, e_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt++;

  doy_date_seq #(.DOY_W(9), .LEAP_EN(1), .SEG_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .doy(doy), .leap(leap),
    .busy(busy), .done(done), .error(error),
    .month_tens(month_tens), .month_ones(month_ones),
    .day_tens(day_tens), .day_ones(day_ones),
    .seg_mt(seg_mt), .seg_mo(seg_mo), .seg_dt(seg_dt), .seg_do(seg_do)
  );

  doy_date_seq #(.DOY_W(10), .LEAP_EN(0), .SEG_ACTIVE_LOW(1)) dut_nl (
    .clk(clk), .rst_n(rst_n), .start(start2), .doy(doy2), .leap(leap2),
    .busy(busy2), .done(done2), .error(error2),
    .month_tens(mt2), .month_ones(mo2),
    .day_tens(dt2), .day_ones(do2),
    .seg_mt(smt2), .seg_mo(smo2), .seg_dt(sdt2), .seg_do(sdo2)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // Active-low {g,f,e,d,c,b,a} patterns for decimal digits
  function automatic int unsigned seg_exp(input int unsigned v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Calendar reference: first day-of-year offset of each month
  function automatic void ref_date(input int unsigned d, input bit lp, output bit err,
                                   output int unsigned mon, output int unsigned dd);
    int unsigned cum [12] = '{0, 31, 59, 90, 120, 151, 181, 212, 243, 273, 304, 334};
    int unsigned ylen;
    int unsigned lo;
    ylen = lp ? 366 : 365;
    err  = (d == 0) || (d > ylen);
    mon  = 0;
    dd   = 0;
    if (!err) begin
      for (int k = 0; k < 12; k++) begin
        lo = cum[k] + ((lp && k >= 2) ? 1 : 0);
        if (d > lo) begin
          mon = k + 1;
          dd  = d - lo;
        end
      end
    end
  endfunction

  task automatic check_outs();
    check("month_tens", month_tens, e_mt);
    check("month_ones", month_ones, e_mo);
    check("day_tens", day_tens, e_dt);
    check("day_ones", day_ones, e_do);
    check("error", error, e_err);
    check("seg_mt", seg_mt, seg_exp(e_mt));
    check("seg_mo", seg_mo, seg_exp(e_mo));
    check("seg_dt", seg_dt, seg_exp(e_dt));
    check("seg_do", seg_do, seg_exp(e_do));
  endtask

  // Caller is #1 after a rising edge with the DUT idle (or start held high).
  task automatic request(input int unsigned d, input bit lp, input bit poke, input bit hold);
    bit          err, seen;
    int unsigned mon, dd, lat, exp_lat, dc0;
    ref_date(d, lp, err, mon, dd);
    dc0   = done_cnt;
    doy   = 9'(d);
    leap  = lp;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    check("busy_after_accept", busy, 1);
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat  = i;
        seen = 1'b1;
        break;
      end
      if (poke && i == 1) begin
        start = 1'b1;
        doy   = 9'($urandom_range(1, 366));
        leap  = ~lp;
      end else if (poke && i == 2) begin
        start = 1'b0;
      end
    end
    if (!hold) start = 1'b0;
    if (!seen) begin
      check("done_timeout", 0, 1);
      return;
    end
    if (!err) begin
      e_mt    = mon / 10;
      e_mo    = mon % 10;
      e_dt    = dd / 10;
      e_do    = dd % 10;
      exp_lat = mon + dd / 10 + 1;
    end else begin
      exp_lat = 1;
    end
    e_err = err;
    check("latency", lat, exp_lat);
    check("busy_with_done", busy, 1);
    check_outs();
    @(posedge clk); #1;
    check("busy_after_done", busy, 0);
    check("done_single", done, 0);
    check("done_count", done_cnt - dc0, 1);
  endtask

  task automatic request_nl(input int unsigned d, input bit lp);
    bit          err, seen;
    int unsigned mon, dd, lat;
    ref_date(d, 1'b0, err, mon, dd);
    doy2   = 10'(d);
    leap2  = lp;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    check("nl_busy", busy2, 1);
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done2) begin
        lat  = i;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check("nl_done_timeout", 0, 1);
      return;
    end
    check("nl_error", error2, err);
    check("nl_latency", lat, err ? 1 : mon + dd / 10 + 1);
    if (!err) begin
      check("nl_month_tens", mt2, mon / 10);
      check("nl_month_ones", mo2, mon % 10);
      check("nl_day_tens", dt2, dd / 10);
      check("nl_day_ones", do2, dd % 10);
      check("nl_seg_mo", smo2, seg_exp(mon % 10));
      check("nl_seg_do", sdo2, seg_exp(dd % 10));
    end
    @(posedge clk); #1;
    check("nl_busy_after_done", busy2, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned dc0;
    rst_n  = 1'b0;
    start  = 1'b0;
    doy    = '0;
    leap   = 1'b0;
    start2 = 1'b0;
    doy2   = '0;
    leap2  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check_outs();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases
    request(1, 0, 0, 0);
    check("jan1_seg_mo", seg_mo, 7'b1111001);
    request(60, 0, 0, 0);
    request(60, 1, 0, 0);
    request(365, 0, 0, 0);
    request(366, 1, 0, 0);
    request(366, 0, 0, 0);
    request(0, 0, 0, 0);
    request(32, 0, 1, 0);
    dc0 = done_cnt;
    repeat (20) @(posedge clk);
    #1;
    check("ignored_start_no_extra_done", done_cnt - dc0, 0);

    // Reset in the middle of a month walk
    doy   = 9'd300;
    leap  = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    dc0   = done_cnt;
    rst_n = 1'b0;
    #1;
    e_mt = 0; e_mo = 0; e_dt = 0; e_do = 0; e_err = 0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check_outs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt - dc0, 0);
    check("midrst_idle", busy, 0);
    request(1, 0, 0, 0);

    // Leap disabled, wide input
    request_nl(60, 1);
    request_nl(366, 1);
    request_nl(512 + 60, 0);
    request_nl(365, 1);

    // Randomized requests with idle gaps and ignored start pokes
    for (int n = 0; n < 150; n++) begin
      request($urandom_range(0, 400), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
    end

    // Full-year sweep with start held high
    for (int lp = 0; lp < 2; lp++) begin
      for (int d = 1; d <= 366; d++) begin
        request(d, lp[0], 0, 1);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
